// File: rtl/analyzer_pkg.sv
// Shared definitions for the analysis scheduler: the FSM state type,
// analyzer bank bit positions and the common widths.
package analyzer_pkg;

  // Width of one requester number and of the analyzer input bus
  localparam int DATA_W  = 32;
  // Number of requesters sharing the analyzer bank
  localparam int NUM_REQ = 2;
  // Number of analyzers in the bank
  localparam int NUM_AN  = 3;
  // Width of the WAIT-state cycle timer
  localparam int TIMER_W = 16;
  // Width of the optional statistics counters
  localparam int STAT_W  = 16;

  // Bit positions inside an_done / an_result / rsp_flags
  localparam int IDX_EVEN = 0;
  localparam int IDX_FIB  = 1;
  localparam int IDX_PAL  = 2;

  // Every analyzer has reported
  localparam logic [NUM_AN-1:0] DONE_ALL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/analysis_scheduler_if.sv
// Bundle of the request, analyzer-bank and response signals of the
// analysis scheduler. The slave modport is the scheduler's view, the
// master modport is the view of whatever surrounds it.
interface analysis_scheduler_if;
  import analyzer_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic [DATA_W-1:0]         an_inp;
  logic                      an_go;
  logic [NUM_AN-1:0]         an_done;
  logic [NUM_AN-1:0]         an_result;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [NUM_AN-1:0]         rsp_flags;
  logic                      rsp_timeout;

  modport slave (
    input  req_valid, req_data, an_done, an_result, rsp_ready,
    output req_ready, an_inp, an_go, rsp_valid, rsp_id, rsp_flags, rsp_timeout
  );

  modport master (
    output req_valid, req_data, an_done, an_result, rsp_ready,
    input  req_ready, an_inp, an_go, rsp_valid, rsp_id, rsp_flags, rsp_timeout
  );

endinterface

// File: rtl/analysis_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with a
// register remembering which requester won last. After reset the
// register points at requester 1 so requester 0 wins the first tie.
module rr_arbiter2
  import analyzer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant_q, last_grant_d;

  // Pick the single requester, or on a tie the one that did not win last
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Remember the winner only when the grant is actually taken
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept && (grant != '0)) begin
      last_grant_d = grant[1];
    end
  end

  // Last-grant register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/analysis_scheduler.sv
// Analysis scheduler: accepts a number from one of two requesters,
// starts the three-analyzer bank on it, collects the done/result
// strobes (or gives up after TIMEOUT_CYCLES WAIT cycles) and hands the
// captured flags to a single response consumer.
// Optional feature: define ANALYZER_STATS_EN to add the saturating
// stat_done / stat_timeout response counters.
module analysis_scheduler
  import analyzer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  analysis_scheduler_if.slave bus
`ifdef ANALYZER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_done,
  output logic [STAT_W-1:0] stat_timeout
`endif
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    an_inp_q, an_inp_d;
  logic                 an_go_q, an_go_d;
  logic [NUM_AN-1:0]    mask_q, mask_d;
  logic [NUM_AN-1:0]    flags_q, flags_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [NUM_AN-1:0]    rsp_flags_q, rsp_flags_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [NUM_AN-1:0]    new_mask;
  logic [NUM_AN-1:0]    new_flags;
  logic [TIMER_W:0]     timer_inc;

  // Requests are only offered to the arbiter while the FSM is idle
  assign arb_req = (state_q == ST_IDLE) ? bus.req_valid : '0;
  assign accept  = |grant;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant)
  );

  // The accept pulse is the grant itself, suppressed while in reset
  assign bus.req_ready = reset ? '0 : grant;

  // Next-state and next-output computation for the scheduler FSM
  always_comb begin
    state_d       = state_q;
    an_inp_d      = an_inp_q;
    an_go_d       = 1'b0;
    mask_d        = mask_q;
    flags_d       = flags_q;
    timer_d       = timer_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;

    new_mask  = mask_q | bus.an_done;
    new_flags = flags_q | (bus.an_done & ~mask_q & bus.an_result);
    timer_inc = {1'b0, timer_q} + (TIMER_W + 1)'(1);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          an_inp_d = grant[1] ? bus.req_data[2*DATA_W-1:DATA_W]
                              : bus.req_data[DATA_W-1:0];
          rsp_id_d = grant[1];
          an_go_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mask_d  = '0;
        flags_d = '0;
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        mask_d  = new_mask;
        flags_d = new_flags;
        timer_d = timer_inc[TIMER_W-1:0];
        if (new_mask == DONE_ALL) begin
          rsp_valid_d   = 1'b1;
          rsp_flags_d   = new_flags;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (timer_inc == (TIMER_W + 1)'(TIMEOUT_CYCLES)) begin
          rsp_valid_d   = 1'b1;
          rsp_flags_d   = new_flags;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      an_inp_q      <= '0;
      an_go_q       <= 1'b0;
      mask_q        <= '0;
      flags_q       <= '0;
      timer_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      an_inp_q      <= an_inp_d;
      an_go_q       <= an_go_d;
      mask_q        <= mask_d;
      flags_q       <= flags_d;
      timer_q       <= timer_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.an_inp      = an_inp_q;
  assign bus.an_go       = an_go_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.rsp_timeout = rsp_timeout_q;

`ifdef ANALYZER_STATS_EN
  logic [STAT_W-1:0] stat_done_q, stat_done_d;
  logic [STAT_W-1:0] stat_timeout_q, stat_timeout_d;
  logic              handoff;

  assign handoff = (state_q == ST_RESP) && bus.rsp_ready;

  // Count each response as it leaves, split by how it was closed
  always_comb begin
    stat_done_d    = stat_done_q;
    stat_timeout_d = stat_timeout_q;
    if (handoff) begin
      if (rsp_timeout_q) begin
        stat_timeout_d = sat_inc(stat_timeout_q);
      end else begin
        stat_done_d = sat_inc(stat_done_q);
      end
    end
  end

  // Statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done_q    <= '0;
      stat_timeout_q <= '0;
    end else begin
      stat_done_q    <= stat_done_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign stat_done    = stat_done_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_analysis_scheduler.sv
// Self-checking bench for analysis_scheduler. Expected responses and
// grants are queued when a request is issued and popped as the DUT
// accepts requests and hands off responses.
module tb_analysis_scheduler;
  import analyzer_pkg::*;

  localparam int unsigned TMO = 4;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [2:0]  flags;
    logic        timeout;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  analysis_scheduler_if bus();

`ifdef ANALYZER_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_timeout;
`endif

  analysis_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ANALYZER_STATS_EN
    ,
    .stat_done    (stat_done),
    .stat_timeout (stat_timeout)
`endif
  );

  always #5 clk = ~clk;

  exp_t        expQ[$];
  logic [1:0]  grantQ[$];
  int          assertCount = 0;
  int          failCount = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          reqLeft[2];
  logic [31:0] reqData[2];
  logic [1:0]  forceValid = 2'b00;
  logic        rspReadyDrive = 1'b1;
  int          anaDelay = 1;
  logic [2:0]  anaMask = 3'b111;
  logic        overrideEn = 1'b0;
  logic [2:0]  overrideVal = 3'b000;
  int          countdown = 0;
  logic [2:0]  anaRes = 3'b000;
  logic        prevGo = 1'b0;
  logic        prevRspValid = 1'b0;
  int          doneSeen = 0;
  int          timeoutSeen = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] refAnalyze(input logic [31:0] n);
    longint unsigned nn, x, r, a, b, t;
    logic [2:0] res;
    nn = 64'(n);
    x = nn;
    r = 0;
    while (x != 0) begin
      r = r * 10 + x % 10;
      x = x / 10;
    end
    a = 0;
    b = 1;
    while (b < nn) begin
      t = a + b;
      a = b;
      b = t;
    end
    res = '0;
    res[IDX_PAL]  = (r == nn);
    res[IDX_FIB]  = (nn == 0) || (b == nn);
    res[IDX_EVEN] = ~n[0];
    return res;
  endfunction

  task automatic applyStimulus(input int id, input logic [31:0] data,
                               input logic [2:0] flags, input logic tmo, input int lat);
    exp_t e;
    e.id = id[0];
    e.data = data;
    e.flags = flags;
    e.timeout = tmo;
    e.lat = lat;
    expQ.push_back(e);
    grantQ.push_back((id == 0) ? 2'b01 : 2'b10);
    reqData[id] = data;
    reqLeft[id]++;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    checkOutput({tag, "_an_go"}, 32'(bus.an_go), 0);
    checkOutput({tag, "_an_inp"}, bus.an_inp, 0);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    checkOutput({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    checkOutput({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 0);
    checkOutput({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() > 0 || grantQ.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(expQ.size() + grantQ.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    timeoutSeen = 0;
  endtask

  // Requester and consumer drivers, updated just after each rising edge
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.req_valid = forceValid | {reqLeft[1] > 0, reqLeft[0] > 0};
      bus.req_data  = {reqData[1], reqData[0]};
      bus.rsp_ready = rspReadyDrive;
    end
  end

  // Analyzer bank model: answers an_go after anaDelay cycles
  initial begin
    bus.an_done   = '0;
    bus.an_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.an_done   = '0;
      bus.an_result = '0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.an_done   = anaMask;
          bus.an_result = anaRes & anaMask;
        end
      end
      if (bus.an_go === 1'b1) begin
        countdown = anaDelay;
        anaRes = overrideEn ? overrideVal : refAnalyze(bus.an_inp);
      end
    end
  end

  // Monitor: grants, go pulses, response latency and response contents
  initial begin
    exp_t e;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.req_ready != '0) begin
          if (grantQ.size() == 0) begin
            checkOutput("unexpected_grant", 32'(bus.req_ready), 0);
          end else begin
            g = grantQ.pop_front();
            checkOutput("grant", 32'(bus.req_ready), 32'(g));
          end
          acceptCycle = cycle;
          for (int i = 0; i < 2; i++) begin
            if (bus.req_ready[i] && reqLeft[i] > 0) reqLeft[i]--;
          end
        end
        if (bus.an_go) begin
          checkOutput("go_single_cycle", 32'(prevGo), 0);
          if (expQ.size() > 0) checkOutput("an_inp_at_go", bus.an_inp, expQ[0].data);
        end
        if (bus.rsp_valid && !prevRspValid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'(bus.rsp_valid), 0);
          end else begin
            checkOutput("latency", 32'(cycle - acceptCycle), 32'(expQ[0].lat));
          end
        end
        if (bus.rsp_valid && bus.rsp_ready && expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          checkOutput("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
          checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
          checkOutput("an_inp_in_resp", bus.an_inp, e.data);
          if (e.timeout) timeoutSeen++;
          else doneSeen++;
        end
        prevGo = bus.an_go;
        prevRspValid = bus.rsp_valid;
      end else begin
        prevGo = 1'b0;
        prevRspValid = 1'b0;
      end
    end
  end

  // Watchdog against a hung run
  initial begin
    #400000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int n;
    reqLeft[0] = 0;
    reqLeft[1] = 0;
    reqData[0] = '0;
    reqData[1] = '0;
    reset = 1'b1;
    forceValid = 2'b11;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    forceValid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single request");
    overrideEn = 1'b1;
    overrideVal = 3'b001;
    applyStimulus(0, 32'd8, 3'b001, 1'b0, 3);
    waitDrain(50);
    overrideEn = 1'b0;

    $display("[TB] contention");
    doReset(2);
    applyStimulus(0, 32'd5, refAnalyze(32'd5), 1'b0, 3);
    applyStimulus(1, 32'd121, refAnalyze(32'd121), 1'b0, 3);
    applyStimulus(0, 32'd5, refAnalyze(32'd5), 1'b0, 3);
    applyStimulus(1, 32'd121, refAnalyze(32'd121), 1'b0, 3);
    waitDrain(100);

    $display("[TB] backpressure");
    rspReadyDrive = 1'b0;
    applyStimulus(0, 32'd34, refAnalyze(32'd34), 1'b0, 3);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_rsp_seen", 32'(bus.rsp_valid), 1);
    applyStimulus(1, 32'd22, refAnalyze(32'd22), 1'b0, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 32'(bus.rsp_valid), 1);
      checkOutput("bp_id_stable", 32'(bus.rsp_id), 32'(expQ[0].id));
      checkOutput("bp_flags_stable", 32'(bus.rsp_flags), 32'(expQ[0].flags));
      checkOutput("bp_timeout_stable", 32'(bus.rsp_timeout), 0);
      checkOutput("bp_no_req_ready", 32'(bus.req_ready), 0);
    end
    rspReadyDrive = 1'b1;
    waitDrain(100);

    $display("[TB] reset during wait");
    anaDelay = 3;
    applyStimulus(0, 32'd8, refAnalyze(32'd8), 1'b0, 3);
    n = 0;
    while (!bus.an_go && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_go_seen", 32'(bus.an_go), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    expQ.delete();
    grantQ.delete();
    reqLeft[0] = 0;
    reqLeft[1] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    anaDelay = 1;
    doneSeen = 0;
    timeoutSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 0);
    end
    applyStimulus(0, 32'd121, refAnalyze(32'd121), 1'b0, 3);
    waitDrain(50);

    $display("[TB] timeout");
    anaMask = 3'b001;
    applyStimulus(0, 32'd10, refAnalyze(32'd10) & 3'b001, 1'b1, int'(TMO) + 2);
    waitDrain(50);
    anaMask = 3'b111;

    $display("[TB] completion on the timeout cycle");
    anaDelay = int'(TMO);
    applyStimulus(1, 32'd3, refAnalyze(32'd3), 1'b0, int'(TMO) + 2);
    waitDrain(50);
    anaDelay = 1;

    applyStimulus(0, 32'd8, refAnalyze(32'd8), 1'b0, 3);
    waitDrain(50);

`ifdef ANALYZER_STATS_EN
    checkOutput("stat_done", 32'(stat_done), 32'(doneSeen));
    checkOutput("stat_timeout", 32'(stat_timeout), 32'(timeoutSeen));
    checkOutput("stat_done_count", 32'(doneSeen), 3);
    checkOutput("stat_timeout_count", 32'(timeoutSeen), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/analysis_scheduler.md
ANALYSIS_SCHEDULER -- requirements
Module: analysis_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, WAIT-state cycle limit before forced completion (1..65535).
REQ-002 Port clk  in  1  single clock, all state on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port req_valid  in  2  per-requester request strobe; bit i = requester i.
REQ-005 Port req_data  in  64  requester i number in bits [32*i+31:32*i].
REQ-006 Port req_ready  out  2  one-hot accept pulse to granted requester.
REQ-007 Port an_inp  out  32  number driven to analyzer bank.
REQ-008 Port an_go  out  1  single-cycle start pulse to analyzer bank.
REQ-009 Port an_done  in  3  completion strobes {palindrome, fibonacci, even}.
REQ-010 Port an_result  in  3  result bits, same order, valid when matching an_done bit is high.
REQ-011 Port rsp_valid  out  1  response available.
REQ-012 Port rsp_ready  in  1  consumer accepts response.
REQ-013 Port rsp_id  out  1  requester index of response.
REQ-014 Port rsp_flags  out  3  captured results {palindrome, fibonacci, even}.
REQ-015 Port rsp_timeout  out  1  response closed by timeout.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; one state per cycle minimum.
REQ-017 IDLE: any req_valid -> grant one requester, req_ready pulses for grantee that same cycle, latch its data into an_inp and id, next ISSUE; no req_valid -> stay IDLE, req_ready=0.
REQ-018 Arbitration round-robin: both valid -> grant the requester not granted last; after reset requester 0 has priority.
REQ-019 ISSUE: an_go=1 for exactly one cycle, clear done mask, flags and timer; next WAIT.
REQ-020 an_inp holds latched number unchanged from ISSUE through end of RESP.
REQ-021 WAIT: each cycle, for each set an_done bit, set its mask bit and capture its an_result bit; repeated strobes on a captured bit ignored.
REQ-022 WAIT: mask==3'b111 (including the cycle completing it) -> RESP, rsp_timeout=0.
REQ-023 WAIT: timer increments per cycle; timer==TIMEOUT_CYCLES with mask incomplete -> RESP, rsp_timeout=1, uncaptured flags=0; mask completion in same cycle wins (rsp_timeout=0).
REQ-024 RESP: rsp_valid=1, rsp_id/rsp_flags/rsp_timeout stable until rsp_ready sampled high; then IDLE next cycle.
REQ-025 an_done strobes outside WAIT ignored.
REQ-026 Total latency with immediate done and rsp_ready high: accept cycle -> rsp_valid 3 cycles later.

Reset
REQ-027 reset asserted: state IDLE, req_ready=0, an_go=0, an_inp=0, rsp_valid=0, rsp_id=0, rsp_flags=0, rsp_timeout=0, timer/mask cleared, priority to requester 0.
REQ-028 reset mid-operation aborts transaction; no response issued; new request accepted only after reset deasserts.

Configuration
REQ-029 Macro ANALYZER_STATS_EN defined: add outputs stat_done (16) and stat_timeout (16), saturating counters of responses handed off without/with timeout, cleared by reset.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package analyzer_pkg holds state enum, DONE_ALL constant (3'b111), done/result bit indices, data width 32.
REQ-032 Sub-module rr_arbiter2 (2-way round-robin, combinational grant plus last-grant register) instantiated once.

Verification
REQ-033 Single request: req_valid=01, data 8, all done one cycle after go with results 3'b001 -> rsp_id=0, rsp_flags=001, rsp_timeout=0.
REQ-034 Contention: both valid continuously, data 5 and 121 -> grants alternate 0,1,0,1; 121 response flags palindrome=1, even=0.
REQ-035 Timeout: TIMEOUT_CYCLES=4, only even done -> rsp_timeout=1, rsp_flags={0,0,even result}, response 4 WAIT cycles after go.
REQ-036 Backpressure: rsp_ready low 10 cycles -> rsp_valid held, outputs stable, no new req_ready pulse.
REQ-037 Reset during WAIT -> outputs return to reset values, no rsp_valid; next request serviced normally.
REQ-038 With ANALYZER_STATS_EN: 3 normal + 1 timeout response -> stat_done=3, stat_timeout=1.
